id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage of the 5-stage MIPS pipeline; drives the EX-stage ALU directly (ALUOperation, Shamt, DataA, DataB).
- Decodes ALU control from main-control ALUOp and funct.
- Forwards from EX/MEM and MEM/WB.
- Detects load-use hazards, and supports stall (hold) and flush (bubble).

---
 rtl/id_ex_stage_if.sv | 36 +++
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side, forwarding and EX-side signals of the ID/EX stage.
interface id_ex_stage_if #(parameter int W = 32, parameter int RW = 5);
    logic          Stall, Flush, IdValid;
    logic          IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdRegDst, IdALUSrc;
    logic [1:0]    IdALUOp;
    logic [5:0]    IdFunct;
    logic [4:0]    IdShamt;
    logic [RW-1:0] IdRs, IdRt, IdRd;
    logic [W-1:0]  IdRsData, IdRtData, IdImm;
    logic          MemRegWrite;
    logic [RW-1:0] MemRd;
    logic [W-1:0]  MemALUResult;
    logic          WbRegWrite;
    logic [RW-1:0] WbRd;
    logic [W-1:0]  WbData;
    logic [2:0]    ALUOperation;
    logic [4:0]    Shamt;
    logic [W-1:0]  DataA, DataB, ExStoreData;
    logic [RW-1:0] ExWriteReg;
    logic          ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;
    logic          IllegalOp, LoadUseStall;
    modport slave (
        input  Stall, Flush, IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdRegDst,
               IdALUSrc, IdALUOp, IdFunct, IdShamt, IdRs, IdRt, IdRd, IdRsData, IdRtData, IdImm,
               MemRegWrite, MemRd, MemALUResult, WbRegWrite, WbRd, WbData,
        output ALUOperation, Shamt, DataA, DataB, ExStoreData, ExWriteReg, ExValid, ExRegWrite,
               ExMemRead, ExMemWrite, ExMemToReg, IllegalOp, LoadUseStall
    );
    modport master (
        output Stall, Flush, IdValid, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdRegDst,
               IdALUSrc, IdALUOp, IdFunct, IdShamt, IdRs, IdRt, IdRd, IdRsData, IdRtData, IdImm,
               MemRegWrite, MemRd, MemALUResult, WbRegWrite, WbRd, WbData,
        input  ALUOperation, Shamt, DataA, DataB, ExStoreData, ExWriteReg, ExValid, ExRegWrite,
               ExMemRead, ExMemWrite, ExMemToReg, IllegalOp, LoadUseStall
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS ID/EX register with ALU-control decode, operand forwarding,
// load-use detection, stall hold (with WB refresh) and flush bubbles.
module id_ex_stage #(parameter int W = 32, parameter int RW = 5) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    logic [RW-1:0] ex_rs, ex_rt;
    logic [W-1:0]  rs_data, rt_data, ex_imm, fwd_rs, fwd_rt;
    logic          ex_alusrc, dec_ill, mem_rs, mem_rt, wb_rs, wb_rt;
    logic [2:0]    dec_op;

    always_comb begin
        dec_op  = 3'b010;
        dec_ill = 1'b0;
        if (bus.IdALUOp == 2'b01)
            dec_op = 3'b110;
        else if (bus.IdALUOp == 2'b11)
            dec_ill = 1'b1;
        else if (bus.IdALUOp == 2'b10)
            case (bus.IdFunct)
                6'h20:   dec_op = 3'b010;
                6'h22:   dec_op = 3'b110;
                6'h24:   dec_op = 3'b000;
                6'h25:   dec_op = 3'b001;
                6'h2A:   dec_op = 3'b111;
                6'h02:   dec_op = 3'b011;
                default: dec_ill = 1'b1;
            endcase
    end

    assign bus.LoadUseStall = bus.ExValid && bus.ExMemRead && bus.ExWriteReg != '0 && bus.IdValid &&
        (bus.ExWriteReg == bus.IdRs || (bus.ExWriteReg == bus.IdRt && (!bus.IdALUSrc || bus.IdMemWrite)));

    // Register 0 is hardwired, so a zero destination never forwards.
    assign mem_rs = bus.MemRegWrite && bus.MemRd != '0 && bus.MemRd == ex_rs;
    assign mem_rt = bus.MemRegWrite && bus.MemRd != '0 && bus.MemRd == ex_rt;
    assign wb_rs  = bus.WbRegWrite && bus.WbRd != '0 && bus.WbRd == ex_rs;
    assign wb_rt  = bus.WbRegWrite && bus.WbRd != '0 && bus.WbRd == ex_rt;
    assign fwd_rs = mem_rs ? bus.MemALUResult : wb_rs ? bus.WbData : rs_data;
    assign fwd_rt = mem_rt ? bus.MemALUResult : wb_rt ? bus.WbData : rt_data;

    assign bus.DataA       = fwd_rs;
    assign bus.DataB       = ex_alusrc ? ex_imm : fwd_rt;
    assign bus.ExStoreData = fwd_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ExValid      <= 1'b0;
            bus.ExRegWrite   <= 1'b0;
            bus.ExMemRead    <= 1'b0;
            bus.ExMemWrite   <= 1'b0;
            bus.ExMemToReg   <= 1'b0;
            bus.ExWriteReg   <= '0;
            bus.ALUOperation <= 3'b000;
            bus.Shamt        <= '0;
            bus.IllegalOp    <= 1'b0;
            ex_alusrc        <= 1'b0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            rs_data          <= '0;
            rt_data          <= '0;
            ex_imm           <= '0;
        end else if (bus.Flush || (!bus.Stall && bus.LoadUseStall)) begin
            bus.ExValid    <= 1'b0;
            bus.ExRegWrite <= 1'b0;
            bus.ExMemRead  <= 1'b0;
            bus.ExMemWrite <= 1'b0;
            bus.ExMemToReg <= 1'b0;
            bus.ExWriteReg <= '0;
            bus.IllegalOp  <= 1'b0;
            ex_alusrc      <= 1'b0;
        end else if (bus.Stall) begin
            // Capture retiring WB values so a long hold never goes stale.
            if (wb_rs) rs_data <= bus.WbData;
            if (wb_rt) rt_data <= bus.WbData;
        end else begin
            bus.ExValid      <= bus.IdValid;
            bus.ExRegWrite   <= bus.IdRegWrite;
            bus.ExMemRead    <= bus.IdMemRead;
            bus.ExMemWrite   <= bus.IdMemWrite;
            bus.ExMemToReg   <= bus.IdMemToReg;
            bus.ExWriteReg   <= bus.IdRegDst ? bus.IdRd : bus.IdRt;
            bus.ALUOperation <= dec_op;
            bus.Shamt        <= bus.IdShamt;
            bus.IllegalOp    <= dec_ill && bus.IdValid;
            ex_alusrc        <= bus.IdALUSrc;
            ex_rs            <= bus.IdRs;
            ex_rt            <= bus.IdRt;
            rs_data          <= bus.IdRsData;
            rt_data          <= bus.IdRtData;
            ex_imm           <= bus.IdImm;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a
// behavioural model of the EX-stage instruction.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    id_ex_stage_if #(.W(32), .RW(5)) bus ();
    id_ex_stage #(.W(32), .RW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit valid, rw, mr, mw, m2r, src, ill, known;
        bit [4:0] rs, rt, wreg, shamt;
        bit [2:0] op;
        bit [31:0] rsd, rtd, imm;
    } st_t;

    st_t m, nx;
    int fmap [int];
    bit [5:0] flist [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h02};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] r, input bit [31:0] d);
        if (bus.MemRegWrite && bus.MemRd != 0 && bus.MemRd == r) return bus.MemALUResult;
        if (bus.WbRegWrite && bus.WbRd != 0 && bus.WbRd == r) return bus.WbData;
        return d;
    endfunction

    function automatic bit lus_model();
        return m.valid && m.mr && m.wreg != 0 && bus.IdValid &&
            (m.wreg == bus.IdRs || (m.wreg == bus.IdRt && (!bus.IdALUSrc || bus.IdMemWrite)));
    endfunction

    function automatic st_t next_state();
        st_t n = m;
        if (bus.Flush || (!bus.Stall && lus_model())) begin
            n.valid = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0; n.src = 0;
            n.wreg = 0; n.ill = 0; n.known = 0;
        end else if (bus.Stall) begin
            if (bus.WbRegWrite && bus.WbRd != 0 && bus.WbRd == m.rs) n.rsd = bus.WbData;
            if (bus.WbRegWrite && bus.WbRd != 0 && bus.WbRd == m.rt) n.rtd = bus.WbData;
        end else begin
            n.valid = bus.IdValid; n.rw = bus.IdRegWrite; n.mr = bus.IdMemRead;
            n.mw = bus.IdMemWrite; n.m2r = bus.IdMemToReg; n.src = bus.IdALUSrc;
            n.rs = bus.IdRs; n.rt = bus.IdRt; n.wreg = bus.IdRegDst ? bus.IdRd : bus.IdRt;
            n.shamt = bus.IdShamt; n.rsd = bus.IdRsData; n.rtd = bus.IdRtData; n.imm = bus.IdImm;
            n.known = 1; n.ill = 0;
            case (bus.IdALUOp)
                2'd0: n.op = 3'd2;
                2'd1: n.op = 3'd6;
                2'd2: if (fmap.exists(int'(bus.IdFunct))) n.op = 3'(fmap[int'(bus.IdFunct)]);
                      else begin n.op = 3'd2; n.ill = 1; end
                default: begin n.op = 3'd2; n.ill = 1; end
            endcase
            n.ill = n.ill && bus.IdValid;
        end
        return n;
    endfunction

    task automatic model_reset();
        m = '{default: 0};
        m.known = 1;
    endtask

    task automatic check_all();
        bit [31:0] fa, fb;
        fa = fwd(m.rs, m.rsd);
        fb = fwd(m.rt, m.rtd);
        chk("ExValid", bus.ExValid, m.valid);
        chk("ExRegWrite", bus.ExRegWrite, m.rw);
        chk("ExMemRead", bus.ExMemRead, m.mr);
        chk("ExMemWrite", bus.ExMemWrite, m.mw);
        chk("ExMemToReg", bus.ExMemToReg, m.m2r);
        chk("ExWriteReg", bus.ExWriteReg, m.wreg);
        chk("IllegalOp", bus.IllegalOp, m.ill);
        chk("LoadUseStall", bus.LoadUseStall, lus_model());
        if (m.known) begin
            chk("ALUOperation", bus.ALUOperation, m.op);
            chk("Shamt", bus.Shamt, m.shamt);
            chk("DataA", bus.DataA, fa);
            chk("DataB", bus.DataB, m.src ? m.imm : fb);
            chk("ExStoreData", bus.ExStoreData, fb);
        end
    endtask

    task automatic step();
        nx = next_state();
        @(posedge clk);
        m = nx;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_fwd();
        bus.MemRegWrite = 0; bus.MemRd = 0; bus.MemALUResult = 0;
        bus.WbRegWrite = 0; bus.WbRd = 0; bus.WbData = 0;
    endtask

    task automatic idle();
        bus.Stall = 0; bus.Flush = 0; bus.IdValid = 0;
        bus.IdRegWrite = 0; bus.IdMemRead = 0; bus.IdMemWrite = 0; bus.IdMemToReg = 0;
        bus.IdRegDst = 0; bus.IdALUSrc = 0; bus.IdALUOp = 0; bus.IdFunct = 0; bus.IdShamt = 0;
        bus.IdRs = 0; bus.IdRt = 0; bus.IdRd = 0; bus.IdRsData = 0; bus.IdRtData = 0; bus.IdImm = 0;
        idle_fwd();
    endtask

    task automatic rtype(input bit [5:0] f, input bit [4:0] rs, rt, rd, input bit [31:0] rsd, rtd);
        idle();
        bus.IdValid = 1; bus.IdRegWrite = 1; bus.IdRegDst = 1; bus.IdALUOp = 2'd2; bus.IdFunct = f;
        bus.IdRs = rs; bus.IdRt = rt; bus.IdRd = rd; bus.IdRsData = rsd; bus.IdRtData = rtd;
        bus.IdShamt = 5'd3;
    endtask

    task automatic itype(input bit ld, st, input bit [4:0] rs, rt, input bit [31:0] imm);
        idle();
        bus.IdValid = 1; bus.IdALUSrc = 1; bus.IdALUOp = 2'd0; bus.IdRegWrite = !st;
        bus.IdMemRead = ld; bus.IdMemToReg = ld; bus.IdMemWrite = st;
        bus.IdRs = rs; bus.IdRt = rt; bus.IdImm = imm;
    endtask

    initial begin
        fmap[6'h20] = 2; fmap[6'h22] = 6; fmap[6'h24] = 0;
        fmap[6'h25] = 1; fmap[6'h2A] = 7; fmap[6'h02] = 3;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        check_all();

        // Decode: slt and an unknown funct
        rtype(6'h2A, 5'd3, 5'd4, 5'd10, 32'd5, 32'd9);
        step();
        chk("slt_op", bus.ALUOperation, 3'b111);
        chk("slt_a", bus.DataA, 32'd5);
        chk("slt_b", bus.DataB, 32'd9);
        chk("slt_wreg", bus.ExWriteReg, 5'd10);
        rtype(6'h3F, 5'd3, 5'd4, 5'd10, 32'd5, 32'd9);
        step();
        chk("bad_funct_op", bus.ALUOperation, 3'b010);
        chk("bad_funct_ill", bus.IllegalOp, 1'b1);

        // Asynchronous reset mid-cycle with a valid instruction held
        rtype(6'h22, 5'd1, 5'd2, 5'd11, 32'd7, 32'd8);
        step();
        #2 rst_n = 0;
        #1;
        chk("rst_valid", bus.ExValid, 1'b0);
        chk("rst_regwrite", bus.ExRegWrite, 1'b0);
        chk("rst_wreg", bus.ExWriteReg, 5'd0);
        chk("rst_op", bus.ALUOperation, 3'b000);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        check_all();

        // Forwarding priority
        rtype(6'h20, 5'd7, 5'd6, 5'd12, 32'h33, 32'h44);
        step();
        bus.MemRegWrite = 1; bus.MemRd = 5'd7; bus.MemALUResult = 32'h11;
        bus.WbRegWrite = 1; bus.WbRd = 5'd7; bus.WbData = 32'h22;
        #1 chk("fwd_mem", bus.DataA, 32'h11);
        bus.MemRegWrite = 0;
        #1 chk("fwd_wb", bus.DataA, 32'h22);
        bus.MemRegWrite = 1; bus.MemRd = 0; bus.WbRd = 0;
        #1 chk("fwd_r0", bus.DataA, 32'h33);
        idle_fwd();

        // Load-use
        itype(1, 0, 5'd1, 5'd8, 32'h10);
        step();
        rtype(6'h20, 5'd8, 5'd2, 5'd3, 32'h1, 32'h2);
        #1 chk("lus_rs", bus.LoadUseStall, 1'b1);
        step();
        chk("lus_bubble_valid", bus.ExValid, 1'b0);
        chk("lus_bubble_rw", bus.ExRegWrite, 1'b0);
        itype(1, 0, 5'd1, 5'd8, 32'h10);
        step();
        itype(0, 0, 5'd1, 5'd8, 32'h4);
        #1 chk("lus_addi", bus.LoadUseStall, 1'b0);

        // Stall with WB refresh of the held Rs
        rtype(6'h20, 5'd5, 5'd6, 5'd13, 32'h0, 32'h9);
        step();
        bus.Stall = 1; bus.IdRsData = 32'h5555;
        step();
        bus.WbRegWrite = 1; bus.WbRd = 5'd5; bus.WbData = 32'hABCD;
        step();
        idle_fwd();
        step();
        bus.Stall = 0;
        #1 chk("stall_refresh", bus.DataA, 32'hABCD);

        // Flush beats Stall; sw operand routing
        rtype(6'h20, 5'd1, 5'd2, 5'd14, 32'h1, 32'h2);
        bus.Flush = 1; bus.Stall = 1;
        step();
        chk("flush_stall", bus.ExValid, 1'b0);
        itype(0, 1, 5'd2, 5'd9, 32'h40);
        bus.IdRtData = 32'h5;
        step();
        bus.MemRegWrite = 1; bus.MemRd = 5'd9; bus.MemALUResult = 32'h77;
        #1 chk("sw_datab", bus.DataB, 32'h40);
        chk("sw_store", bus.ExStoreData, 32'h77);
        idle_fwd();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.IdValid = ($urandom_range(0, 7) != 0);
            bus.IdRegWrite = 1'($urandom); bus.IdMemRead = 1'($urandom);
            bus.IdMemWrite = 1'($urandom); bus.IdMemToReg = 1'($urandom);
            bus.IdRegDst = 1'($urandom); bus.IdALUSrc = 1'($urandom);
            bus.IdALUOp = 2'($urandom);
            bus.IdFunct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flist[$urandom_range(0, 5)];
            bus.IdShamt = 5'($urandom);
            bus.IdRs = 5'($urandom_range(0, 7)); bus.IdRt = 5'($urandom_range(0, 7));
            bus.IdRd = 5'($urandom_range(0, 7));
            bus.IdRsData = $urandom; bus.IdRtData = $urandom; bus.IdImm = $urandom;
            bus.MemRegWrite = 1'($urandom); bus.MemRd = 5'($urandom_range(0, 7));
            bus.MemALUResult = $urandom;
            bus.WbRegWrite = 1'($urandom); bus.WbRd = 5'($urandom_range(0, 7));
            bus.WbData = $urandom;
            bus.Stall = ($urandom_range(0, 3) == 0);
            bus.Flush = ($urandom_range(0, 7) == 0);
            #1 check_all();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
